// File: rtl/udp_panel_dispatcher_if.sv
// Bundles the two streaming sides of the UDP-to-panel dispatcher.
//   udp0_source_* : byte stream from the Ethernet core (valid/ready, last, error, data)
//   ctrl_*        : pixel write bus towards the ledpanel buffers (wr/ready, en, addr, wdat)
// Modports:
//   master : the dispatcher itself (master of the ctrl bus, sink of the UDP stream)
//   slave  : the surrounding environment (UDP source and panel ctrl ports)
interface udp_panel_dispatcher_if #(
    parameter int unsigned NUM_PANELS = 9,
    parameter int unsigned ADDR_W     = 16
);
    logic                  udp0_source_valid;
    logic                  udp0_source_last;
    logic                  udp0_source_ready;
    logic [7:0]            udp0_source_data;
    logic                  udp0_source_error;

    logic [NUM_PANELS-1:0] ctrl_en;
    logic                  ctrl_wr;
    logic                  ctrl_ready;
    logic [ADDR_W-1:0]     ctrl_addr;
    logic [23:0]           ctrl_wdat;

    modport master (
        input  udp0_source_valid,
        input  udp0_source_last,
        output udp0_source_ready,
        input  udp0_source_data,
        input  udp0_source_error,
        output ctrl_en,
        output ctrl_wr,
        input  ctrl_ready,
        output ctrl_addr,
        output ctrl_wdat
    );

    modport slave (
        output udp0_source_valid,
        output udp0_source_last,
        input  udp0_source_ready,
        output udp0_source_data,
        output udp0_source_error,
        input  ctrl_en,
        input  ctrl_wr,
        output ctrl_ready,
        input  ctrl_addr,
        input  ctrl_wdat
    );
endinterface

// File: rtl/udp_panel_dispatcher.sv
// UDP payload parser that turns pixel packets into 24-bit RGB writes to NUM_PANELS panel buffers.
// Packet layout: CMD, PANEL, ADDR_HI, ADDR_LO, payload.
//   CMD 0x01: payload is R,G,B triplets written to consecutive addresses (wrapping).
//   CMD 0x02: bit0 of the first payload byte sets led_reg.
//   PANEL < NUM_PANELS selects one panel, PANEL == BCAST_ID selects all of them.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   bus          : udp0_source_* stream in, ctrl_* write bus out (udp_panel_dispatcher_if.master)
//   led_reg      : status LED register
//   pkt_ok       : packets completed cleanly (saturating, UDP_DISPATCH_STATS_EN only)
//   pkt_drop     : packets discarded, truncated or errored (saturating, UDP_DISPATCH_STATS_EN only)
// Optional feature: define UDP_DISPATCH_STATS_EN to add the pkt_ok/pkt_drop counters.
module udp_panel_dispatcher #(
    parameter int unsigned NUM_PANELS = 9,
    parameter int unsigned ADDR_W     = 16,
    parameter logic [7:0]  BCAST_ID   = 8'hFF
) (
    input  logic                          clock,
    input  logic                          reset,
    udp_panel_dispatcher_if.master        bus,
`ifdef UDP_DISPATCH_STATS_EN
    output logic [15:0]                   pkt_ok,
    output logic [15:0]                   pkt_drop,
`endif
    output logic                          led_reg
);

    localparam logic [7:0] CmdPixel = 8'h01;
    localparam logic [7:0] CmdLed   = 8'h02;

    typedef enum logic [2:0] {
        S_CMD,
        S_PANEL,
        S_AHI,
        S_ALO,
        S_PIX,
        S_LED,
        S_DISCARD
    } state_e;

    state_e                state_q;
    logic [7:0]            cmd_q;
    logic [NUM_PANELS-1:0] mask_q;
    logic [7:0]            addr_hi_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [1:0]            byte_cnt_q;
    logic [7:0]            red_q;
    logic [7:0]            green_q;

    logic                  ctrl_wr_q;
    logic [NUM_PANELS-1:0] ctrl_en_q;
    logic [ADDR_W-1:0]     ctrl_addr_q;
    logic [23:0]           ctrl_wdat_q;
    logic                  led_q;

    logic                  stall_b;
    logic                  accept;
    logic                  bad_end;
    logic [NUM_PANELS-1:0] panel_onehot;
    logic                  panel_valid;
    logic                  panel_bcast;

    // Only a completing B byte has to wait for the pending write; R and G of the next
    // triplet are collected underneath it.
    assign stall_b = ctrl_wr_q && !bus.ctrl_ready && (state_q == S_PIX) && (byte_cnt_q == 2'd2);
    assign accept  = bus.udp0_source_valid && !stall_b;

    // An errored last byte suppresses the side effect it would otherwise cause.
    assign bad_end = bus.udp0_source_last && bus.udp0_source_error;

    always_comb begin
        panel_onehot = '0;
        for (int unsigned i = 0; i < NUM_PANELS; i++) begin
            panel_onehot[i] = (bus.udp0_source_data == 8'(i));
        end
    end

    assign panel_valid = ({24'd0, bus.udp0_source_data} < NUM_PANELS);
    assign panel_bcast = (bus.udp0_source_data == BCAST_ID);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_CMD;
            cmd_q       <= '0;
            mask_q      <= '0;
            addr_hi_q   <= '0;
            addr_q      <= '0;
            byte_cnt_q  <= '0;
            red_q       <= '0;
            green_q     <= '0;
            ctrl_wr_q   <= 1'b0;
            ctrl_en_q   <= '0;
            ctrl_addr_q <= '0;
            ctrl_wdat_q <= '0;
            led_q       <= 1'b0;
        end else begin
            // Retire the pending write; a triplet completing this same cycle re-arms it below.
            if (ctrl_wr_q && bus.ctrl_ready) begin
                ctrl_wr_q <= 1'b0;
            end

            if (accept) begin
                case (state_q)
                    S_CMD: begin
                        cmd_q   <= bus.udp0_source_data;
                        state_q <= S_PANEL;
                    end
                    S_PANEL: begin
                        if (panel_valid) begin
                            mask_q  <= panel_onehot;
                            state_q <= S_AHI;
                        end else if (panel_bcast) begin
                            mask_q  <= '1;
                            state_q <= S_AHI;
                        end else begin
                            state_q <= S_DISCARD;
                        end
                    end
                    S_AHI: begin
                        addr_hi_q <= bus.udp0_source_data;
                        state_q   <= S_ALO;
                    end
                    S_ALO: begin
                        addr_q     <= ADDR_W'({addr_hi_q, bus.udp0_source_data});
                        byte_cnt_q <= 2'd0;
                        if (cmd_q == CmdPixel) begin
                            state_q <= S_PIX;
                        end else if (cmd_q == CmdLed) begin
                            state_q <= S_LED;
                        end else begin
                            state_q <= S_DISCARD;
                        end
                    end
                    S_PIX: begin
                        case (byte_cnt_q)
                            2'd0: begin
                                red_q      <= bus.udp0_source_data;
                                byte_cnt_q <= 2'd1;
                            end
                            2'd1: begin
                                green_q    <= bus.udp0_source_data;
                                byte_cnt_q <= 2'd2;
                            end
                            default: begin
                                byte_cnt_q <= 2'd0;
                                if (!bad_end) begin
                                    ctrl_wr_q   <= 1'b1;
                                    ctrl_en_q   <= mask_q;
                                    ctrl_addr_q <= addr_q;
                                    ctrl_wdat_q <= {red_q, green_q, bus.udp0_source_data};
                                    addr_q      <= addr_q + ADDR_W'(1);
                                end
                            end
                        endcase
                    end
                    S_LED: begin
                        if (!bad_end) begin
                            led_q <= bus.udp0_source_data[0];
                        end
                        state_q <= S_DISCARD;
                    end
                    default: begin
                        // S_DISCARD: swallow bytes until last.
                    end
                endcase

                if (bus.udp0_source_last) begin
                    state_q <= S_CMD;
                end
            end
        end
    end

`ifdef UDP_DISPATCH_STATS_EN
    logic        bad_hdr_q;  // set when the header sent the packet to S_DISCARD
    logic        pkt_end_ok;
    logic [15:0] pkt_ok_q;
    logic [15:0] pkt_drop_q;

    always_comb begin
        case (state_q)
            S_ALO:     pkt_end_ok = (cmd_q == CmdPixel) || (cmd_q == CmdLed);
            S_PIX:     pkt_end_ok = (byte_cnt_q == 2'd2);
            S_LED:     pkt_end_ok = 1'b1;
            S_DISCARD: pkt_end_ok = !bad_hdr_q;
            default:   pkt_end_ok = 1'b0;
        endcase
        if (bus.udp0_source_error) begin
            pkt_end_ok = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bad_hdr_q  <= 1'b0;
            pkt_ok_q   <= '0;
            pkt_drop_q <= '0;
        end else if (accept) begin
            if (state_q == S_CMD) begin
                bad_hdr_q <= 1'b0;
            end else if (state_q == S_PANEL && !panel_valid && !panel_bcast) begin
                bad_hdr_q <= 1'b1;
            end else if (state_q == S_ALO && cmd_q != CmdPixel && cmd_q != CmdLed) begin
                bad_hdr_q <= 1'b1;
            end

            if (bus.udp0_source_last) begin
                if (pkt_end_ok) begin
                    if (pkt_ok_q != 16'hFFFF) begin
                        pkt_ok_q <= pkt_ok_q + 16'd1;
                    end
                end else if (pkt_drop_q != 16'hFFFF) begin
                    pkt_drop_q <= pkt_drop_q + 16'd1;
                end
            end
        end
    end

    assign pkt_ok   = pkt_ok_q;
    assign pkt_drop = pkt_drop_q;
`endif

    assign bus.udp0_source_ready = !stall_b;
    assign bus.ctrl_wr           = ctrl_wr_q;
    assign bus.ctrl_en           = ctrl_en_q;
    assign bus.ctrl_addr         = ctrl_addr_q;
    assign bus.ctrl_wdat         = ctrl_wdat_q;
    assign led_reg               = led_q;

endmodule

// File: tb/tb_udp_panel_dispatcher.sv
module tb_udp_panel_dispatcher;

    logic clock = 1'b0;
    logic reset;
    logic led_reg;
`ifdef UDP_DISPATCH_STATS_EN
    logic [15:0] pkt_ok;
    logic [15:0] pkt_drop;
`endif

    udp_panel_dispatcher_if #(.NUM_PANELS(9), .ADDR_W(16)) bus ();

    udp_panel_dispatcher #(
        .NUM_PANELS(9),
        .ADDR_W    (16),
        .BCAST_ID  (8'hFF)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus),
`ifdef UDP_DISPATCH_STATS_EN
        .pkt_ok  (pkt_ok),
        .pkt_drop(pkt_drop),
`endif
        .led_reg (led_reg)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [8:0]  en;
        logic [15:0] addr;
        logic [23:0] wdat;
    } wr_t;

    wr_t wq[$];
    int  n_checks = 0;
    int  n_errors = 0;
    int  stall_log[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write-bus monitor: logs every handshake and checks the fields hold while stalled.
    logic  stall_seen = 1'b0;
    wr_t   held;
    always @(posedge clock) begin
        if (reset) begin
            stall_seen = 1'b0;
        end else begin
            if (stall_seen) begin
                check_eq("stable_en", 64'(bus.ctrl_en), 64'(held.en));
                check_eq("stable_addr", 64'(bus.ctrl_addr), 64'(held.addr));
                check_eq("stable_wdat", 64'(bus.ctrl_wdat), 64'(held.wdat));
            end
            if (bus.ctrl_wr && bus.ctrl_ready) begin
                wq.push_back({bus.ctrl_en, bus.ctrl_addr, bus.ctrl_wdat});
            end
            stall_seen = bus.ctrl_wr && !bus.ctrl_ready;
            held = {bus.ctrl_en, bus.ctrl_addr, bus.ctrl_wdat};
        end
    end

    // Present one byte until accepted; logs how many edges it was held off.
    task automatic send_byte(input logic [7:0] d, input logic l, input logic e);
        logic acc;
        int   n;
        n = 0;
        bus.udp0_source_valid = 1'b1;
        bus.udp0_source_data  = d;
        bus.udp0_source_last  = l;
        bus.udp0_source_error = e;
        do begin
            @(negedge clock);
            acc = bus.udp0_source_ready;
            @(posedge clock);
            #1;
            n++;
        end while (!acc && n < 100);
        if (!acc) check_eq("byte_accept_timeout", 64'(acc), 64'd1);
        stall_log.push_back(n - 1);
        bus.udp0_source_valid = 1'b0;
        bus.udp0_source_last  = 1'b0;
        bus.udp0_source_error = 1'b0;
    endtask

    // Last byte carries last=1 when with_last, and error=err.
    task automatic send_pkt(input logic [7:0] b[$], input logic with_last, input logic err);
        for (int i = 0; i < b.size(); i++) begin
            if (i == b.size() - 1 && with_last) send_byte(b[i], 1'b1, err);
            else send_byte(b[i], 1'b0, 1'b0);
        end
    endtask

    task automatic drain();
        repeat (4) @(posedge clock);
        #1;
    endtask

    task automatic expect_wr(input int idx, input logic [8:0] en, input logic [15:0] a,
                             input logic [23:0] w);
        if (idx < wq.size()) begin
            check_eq("wr_en", 64'(wq[idx].en), 64'(en));
            check_eq("wr_addr", 64'(wq[idx].addr), 64'(a));
            check_eq("wr_wdat", 64'(wq[idx].wdat), 64'(w));
        end else begin
            check_eq("wr_count_short", 64'(wq.size()), 64'(idx + 1));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] p[$];
        int         n;

        reset = 1'b1;
        bus.udp0_source_valid = 1'b0;
        bus.udp0_source_last  = 1'b0;
        bus.udp0_source_error = 1'b0;
        bus.udp0_source_data  = 8'h00;
        bus.ctrl_ready        = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_wr", 64'(bus.ctrl_wr), 64'd0);
        check_eq("rst_en", 64'(bus.ctrl_en), 64'd0);
        check_eq("rst_addr", 64'(bus.ctrl_addr), 64'd0);
        check_eq("rst_wdat", 64'(bus.ctrl_wdat), 64'd0);
        check_eq("rst_led", 64'(led_reg), 64'd0);
        check_eq("rst_ready", 64'(bus.udp0_source_ready), 64'd1);
        reset = 1'b0;

        // Two pixels to panel 2.
        wq.delete();
        p = {8'h01, 8'h02, 8'h00, 8'h10, 8'hAA, 8'hBB, 8'hCC, 8'h11, 8'h22, 8'h33};
        send_pkt(p, 1'b1, 1'b0);
        drain();
        check_eq("p2_count", 64'(wq.size()), 64'd2);
        expect_wr(0, 9'b000000100, 16'h0010, 24'hAABBCC);
        expect_wr(1, 9'b000000100, 16'h0011, 24'h112233);

        // Broadcast with address wrap.
        wq.delete();
        p = {8'h01, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_pkt(p, 1'b1, 1'b0);
        drain();
        check_eq("bc_count", 64'(wq.size()), 64'd2);
        expect_wr(0, 9'h1FF, 16'hFFFF, 24'h010203);
        expect_wr(1, 9'h1FF, 16'h0000, 24'h040506);

        // Backpressure: ctrl_ready low for 5 edges after the first write appears.
        wq.delete();
        stall_log.delete();
        bus.ctrl_ready = 1'b0;
        p = {8'h01, 8'h04, 8'h00, 8'h20, 8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22,
             8'h30, 8'h31, 8'h32};
        fork
            send_pkt(p, 1'b1, 1'b0);
            begin
                n = 0;
                do begin
                    @(posedge clock);
                    #1;
                    n++;
                end while (!bus.ctrl_wr && n < 50);
                check_eq("bp_wr_seen", 64'(bus.ctrl_wr), 64'd1);
                repeat (5) @(posedge clock);
                #1;
                bus.ctrl_ready = 1'b1;
            end
        join
        drain();
        check_eq("bp_r2_nostall", 64'(stall_log[7]), 64'd0);
        check_eq("bp_g2_nostall", 64'(stall_log[8]), 64'd0);
        check_eq("bp_b2_stall", 64'(stall_log[9]), 64'd3);
        check_eq("bp_b3_nostall", 64'(stall_log[12]), 64'd0);
        check_eq("bp_count", 64'(wq.size()), 64'd3);
        expect_wr(0, 9'h010, 16'h0020, 24'h101112);
        expect_wr(1, 9'h010, 16'h0021, 24'h202122);
        expect_wr(2, 9'h010, 16'h0022, 24'h303132);

        // Invalid panel and invalid command, then a good packet.
        wq.delete();
        p = {8'h01, 8'h09, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC};
        send_pkt(p, 1'b1, 1'b0);
        p = {8'h07, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC};
        send_pkt(p, 1'b1, 1'b0);
        drain();
        check_eq("bad_hdr_nowr", 64'(wq.size()), 64'd0);
        p = {8'h01, 8'h05, 8'h12, 8'h34, 8'h01, 8'h02, 8'h03};
        send_pkt(p, 1'b1, 1'b0);
        drain();
        check_eq("after_bad_count", 64'(wq.size()), 64'd1);
        expect_wr(0, 9'h020, 16'h1234, 24'h010203);

        // LED set, errored clear suppressed, clean clear applied.
        p = {8'h02, 8'h00, 8'h00, 8'h00, 8'h01};
        send_pkt(p, 1'b1, 1'b0);
        drain();
        check_eq("led_set", 64'(led_reg), 64'd1);
        p = {8'h02, 8'h00, 8'h00, 8'h00, 8'h00};
        send_pkt(p, 1'b1, 1'b1);
        drain();
        check_eq("led_err_hold", 64'(led_reg), 64'd1);
        p = {8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h55};
        send_pkt(p, 1'b1, 1'b0);
        drain();
        check_eq("led_clear", 64'(led_reg), 64'd0);

        // Truncations: mid-triplet, in header, zero-pixel; then resync on a good packet.
        wq.delete();
        p = {8'h01, 8'h00, 8'h00, 8'h40, 8'hAA, 8'hBB};
        send_pkt(p, 1'b1, 1'b0);
        p = {8'h01, 8'h00};
        send_pkt(p, 1'b1, 1'b0);
        p = {8'h01, 8'h00, 8'h00, 8'h60};
        send_pkt(p, 1'b1, 1'b0);
        drain();
        check_eq("trunc_nowr", 64'(wq.size()), 64'd0);
        p = {8'h01, 8'h03, 8'h00, 8'h50, 8'h01, 8'h02, 8'h03};
        send_pkt(p, 1'b1, 1'b0);
        drain();
        check_eq("resync_count", 64'(wq.size()), 64'd1);
        expect_wr(0, 9'h008, 16'h0050, 24'h010203);

        // Reset while a write is pending drops it.
        wq.delete();
        bus.ctrl_ready = 1'b0;
        p = {8'h01, 8'h00, 8'h00, 8'h70, 8'h01, 8'h02, 8'h03};
        send_pkt(p, 1'b0, 1'b0);
        check_eq("pend_wr", 64'(bus.ctrl_wr), 64'd1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_eq("rst_mid_wr", 64'(bus.ctrl_wr), 64'd0);
        check_eq("rst_mid_ready", 64'(bus.udp0_source_ready), 64'd1);
        reset = 1'b0;
        bus.ctrl_ready = 1'b1;
        p = {8'h01, 8'h01, 8'h00, 8'h80, 8'h0A, 8'h0B, 8'h0C};
        send_pkt(p, 1'b1, 1'b0);
        drain();
        check_eq("post_rst_count", 64'(wq.size()), 64'd1);
        expect_wr(0, 9'h002, 16'h0080, 24'h0A0B0C);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/udp_panel_dispatcher.md
Name: udp_panel_dispatcher

Overview:
- Parametrised successor to the UDP-to-panel write path.
- Parses the UDP payload stream from the Ethernet core and issues 24-bit RGB pixel writes to NUM_PANELS panel buffers.
- Targets one panel or broadcasts to all, and applies ctrl-bus backpressure to the UDP source.
- Sits between the Ethernet core's udp0_source interface and the per-panel ledpanel ctrl ports, in the sys clock domain.

Parameters:
NUM_PANELS, 9, number of panels; width of ctrl_en (1..32)
ADDR_W, 16, pixel address width; address wraps mod 2^ADDR_W
BCAST_ID, 8'hFF, panel-index value meaning "all panels"

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
udp0_source_valid  in  1  payload byte valid
udp0_source_last  in  1  last byte of packet
udp0_source_ready  out  1  byte accepted when valid&ready
udp0_source_data  in  8  payload byte
udp0_source_error  in  1  packet error, sampled with last
ctrl_en  out  NUM_PANELS  panel select mask, valid while ctrl_wr=1
ctrl_wr  out  1  write request; held until ctrl_ready
ctrl_ready  in  1  write accepted when ctrl_wr&ctrl_ready
ctrl_addr  out  ADDR_W  pixel address
ctrl_wdat  out  24  {R,G,B}
led_reg  out  1  status LED register

Behaviour:
- Packet format (byte order): CMD, PANEL, ADDR_HI, ADDR_LO, then payload.
  - CMD 0x01 = pixel write: payload is R,G,B triplets.
  - CMD 0x02 = LED: first payload byte bit0 -> led_reg.
  - Any other CMD -> discard packet.
- Start address = {ADDR_HI,ADDR_LO}[ADDR_W-1:0]; upper bits ignored when ADDR_W<16.
- FSM states: S_CMD, S_PANEL, S_AHI, S_ALO, S_PIX, S_LED, S_DISCARD. Reset state S_CMD.
  - S_CMD -> S_PANEL on an accepted byte; the byte is latched as the command.
  - S_PANEL: PANEL<NUM_PANELS -> one-hot mask; PANEL==BCAST_ID -> all-ones mask; else S_DISCARD.
  - S_ALO -> S_PIX when CMD=0x01; S_LED when CMD=0x02; S_DISCARD otherwise.
  - S_PIX: byte counter 0..2 collects R, G, B. On B accept, load ctrl_addr/ctrl_wdat/ctrl_en and assert ctrl_wr the next cycle. Address then increments, wrapping 2^ADDR_W-1 -> 0.
  - S_LED: first byte updates led_reg, then S_DISCARD (unless last).
  - Accepted byte with last=1 in any state -> S_CMD next cycle.
- Ready rule: udp0_source_ready=0 only when ctrl_wr=1 && ctrl_ready=0 && state=S_PIX; otherwise 1.
  - This allows the next R,G bytes to be collected while a write is pending.
  - A new B byte stalls until the pending write completes.
- ctrl_wr:
  - Deasserts the cycle after a handshake unless a new triplet completes that same cycle, in which case ctrl_wr stays 1 with new data.
  - ctrl_addr/ctrl_wdat/ctrl_en stable while ctrl_wr=1 && ctrl_ready=0.
- Boundaries:
  - Last before header complete: no writes, packet dropped.
  - Last mid-triplet: partial triplet discarded.
  - Error with last: writes already issued stand, no retraction; LED update suppressed if error coincides with its byte.
  - Zero-pixel packet (last on ADDR_LO): no writes.
- Reset outputs:
  - ctrl_wr=0, ctrl_en=0, ctrl_addr=0, ctrl_wdat=0, led_reg=0, udp0_source_ready=1.
  - Reset mid-write drops the pending write; FSM returns to S_CMD.

Optional Feature:
- Macro: UDP_DISPATCH_STATS_EN.
- Defined:
  - Adds outputs pkt_ok[15:0] and pkt_drop[15:0], both saturating at 16'hFFFF and reset to 0.
  - pkt_ok increments on last of a packet completing with error=0 and not discarded.
  - pkt_drop increments on last of a packet that was discarded, truncated in the header, or had error=1.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Pixel write, panel 2: bytes 01 02 00 10 AA BB CC 11 22 33(last), ctrl_ready=1 -> two writes: en=9'b000000100, addr=0x0010 wdat=AABBCC; addr=0x0011 wdat=112233.
- Broadcast with wrap: 01 FF FF FF 01 02 03 04 05 06(last) -> en=9'h1FF; addr 0xFFFF then 0x0000.
- Backpressure: ctrl_ready held 0 for 5 cycles during a 3-pixel stream -> ready drops on the 2nd B byte; ctrl fields stable; all 3 writes complete in order, none lost or duplicated.
- Invalid panel 0x09 and CMD 0x07 -> zero ctrl_wr pulses; next valid packet processed normally.
- LED packet 02 00 00 00 01(last) -> led_reg=1; then 02 00 00 00 00 with error=1 -> led_reg stays 1.
- Truncation/reset: last on G byte -> no write. Reset asserted while ctrl_wr=1 -> ctrl_wr=0 next cycle. With UDP_DISPATCH_STATS_EN defined, pkt_drop counts each such packet.
